bf16_issue_queue: RTL
=====================

// Module: bf16_issue_queue
// PURPOSE
// - Operand/instruction buffer directly upstream of the BF16 SIMD operand decoder.
// - Accepts {funct5, rs1, rs2, rs3} packed-SIMD BF16 instructions over a valid/ready handshake.
// - Holds up to DEPTH instructions in order and presents the oldest to the decoder/FMA lanes.
// - Tags entries whose funct5 is outside the supported op set.
// PARAMETERS
// - LANES  2  BF16 lanes per operand; each operand is 16*LANES bits, lane i = bits [16*i+15:16*i].
// - DEPTH  2  queue entries, >=1, need not be a power of two.
// PORTS
// - clk         in   1         single clock, rising edge.
// - rst_n       in   1         asynchronous, active-low reset.
// - flush       in   1         synchronous queue clear.
// - in_valid    in   1         producer has an instruction.
// - in_ready    out  1         queue can accept.
// - in_funct5   in   5         operation code.
// - in_rs1      in   16*LANES  operand 1, packed lanes.
// - in_rs2      in   16*LANES  operand 2, packed lanes.
// - in_rs3      in   16*LANES  operand 3, packed lanes.
// - out_valid   out  1         head entry present.
// - out_ready   in   1         decoder stage consumes head.
// - out_funct5  out  5         head funct5.
// - out_rs1     out  16*LANES  head operand 1.
// - out_rs2     out  16*LANES  head operand 2.
// - out_rs3     out  16*LANES  head operand 3.
// - out_illegal out  1         head funct5 not in the legal set.
// - err_sticky  out  1         an illegal funct5 has been accepted since reset/flush.
// - count       out  $clog2(DEPTH+1)  current occupancy.
// BEHAVIOUR
// Reset and handshake
// - Reset (rst_n=0, async): count=0, wr_ptr=rd_ptr=0, all storage zeroed.
//   Reset also forces out_valid=0, out_* data=0, out_illegal=0 and err_sticky=0; in_ready=1 after release.
// - Push when in_valid&&in_ready. Pop when out_valid&&out_ready.
// - in_ready = (count<DEPTH). It is registered-state only, with no combinational path from out_ready.
//   Consequence: a full queue does not accept a push, even if it pops in the same cycle.
// - out_valid = (count!=0). out_* are driven combinationally from storage[rd_ptr].
//   out_* are held stable while out_valid && !out_ready.
// Timing and ordering
// - Latency: an instruction pushed at edge N is visible on out_* after edge N. No bypass, so minimum latency is 1 cycle.
// - Order: strict FIFO.
// - Simultaneous push+pop (count in 1..DEPTH-1): count is unchanged and both pointers advance.
// - Pointer wrap: a pointer at DEPTH-1 advances to 0.
// - Pop with count=0 is impossible (out_valid=0). Push with count=DEPTH is impossible (in_ready=0).
// Illegal-op tagging
// - Legal funct5 set: 5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b00101.
// - An illegal funct5 is still enqueued with its operands unchanged, and its entry tag is set to 1.
// - out_illegal = tag of the head entry.
// - err_sticky sets on the accepting edge of an illegal push. It clears only on reset or flush.
// Flush
// - flush=1 at an edge: count=0, pointers=0, err_sticky=0. Storage contents are don't-care.
// - Flush has priority: any push or pop in the same cycle is discarded, and the producer's handshake is lost.
// - out_valid=0 from the next cycle.
// - Reset asserted mid-operation discards all entries immediately, asynchronously.
// Widths
// - count has width $clog2(DEPTH+1). The pointers have width max(1,$clog2(DEPTH)).
// STRUCTURE
// - Shared package bf16_pkg:
//   - FUNCT5 localparams: OP_ADD=5'b00000, OP_SUB=5'b00001, OP_MUL=5'b00010, OP_FMADD=5'b00100, OP_FMSUB=5'b00101.
//   - function is_legal_funct5.
//   - BF16_ONE=16'h3F80.
//   - The decoder uses the same package.
// - No sub-modules. Storage arrays, pointer/count logic, the legality check and the sticky flag are all in one module.
// TESTING
// - Reset, then push funct5=00100, rs1=32'h3F80_4000, rs2=32'h4040_4080, rs3=0, with out_ready=0
//   -> next cycle out_valid=1, out_* match, count=1. out_* are stable for 3 held cycles.
// - DEPTH=2: push A then B with out_ready=0 -> count=2, in_ready=0. A third push is not accepted.
//   Then out_ready=1 -> A, then B, in order. in_ready=1 after the first pop.
// - count=1 with simultaneous push C and pop -> count stays 1, the new head is C. Repeat 5 times to exercise pointer wrap.
// - Push funct5=5'b00011 -> out_illegal=1 and err_sticky=1. After that entry is popped, a legal head shows out_illegal=0
//   while err_sticky stays 1.
// - count=2 and flush with in_valid=1 in the same cycle -> count=0, out_valid=0, err_sticky=0, the pushed item is dropped.
// - Drop rst_n asynchronously mid-cycle with count=2 -> out_valid=0 and count=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/bf16_pkg.sv
// rtl/bf16_pkg.sv - shared BF16 SIMD opcode constants and legality check
package bf16_pkg;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_MUL   = 5'b00010;
    localparam logic [4:0] OP_FMADD = 5'b00100;
    localparam logic [4:0] OP_FMSUB = 5'b00101;

    localparam logic [15:0] BF16_ONE = 16'h3F80;

    function automatic logic is_legal_funct5(input logic [4:0] f);
        case (f)
            OP_ADD, OP_SUB, OP_MUL, OP_FMADD, OP_FMSUB: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bf16_issue_queue.sv
// rtl/bf16_issue_queue.sv - in-order BF16 SIMD instruction buffer ahead of the operand decoder
module bf16_issue_queue
    import bf16_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [4:0]                  in_funct5,
    input  logic [16*LANES-1:0]         in_rs1,
    input  logic [16*LANES-1:0]         in_rs2,
    input  logic [16*LANES-1:0]         in_rs3,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [4:0]                  out_funct5,
    output logic [16*LANES-1:0]         out_rs1,
    output logic [16*LANES-1:0]         out_rs2,
    output logic [16*LANES-1:0]         out_rs3,
    output logic                        out_illegal,
    output logic                        err_sticky,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int W     = 16 * LANES;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [4:0]       st_funct5 [DEPTH];
    logic [W-1:0]     st_rs1    [DEPTH];
    logic [W-1:0]     st_rs2    [DEPTH];
    logic [W-1:0]     st_rs3    [DEPTH];
    logic             st_tag    [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             sticky;
    logic             push;
    logic             pop;
    logic             in_legal;

    // in_ready depends only on occupancy, so a full queue never accepts even while popping
    assign in_ready    = (count < CNT_FULL);
    assign out_valid   = (count != '0);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign in_legal    = is_legal_funct5(in_funct5);

    assign out_funct5  = st_funct5[rd_ptr];
    assign out_rs1     = st_rs1[rd_ptr];
    assign out_rs2     = st_rs2[rd_ptr];
    assign out_rs3     = st_rs3[rd_ptr];
    assign out_illegal = st_tag[rd_ptr];
    assign err_sticky  = sticky;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sticky <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sticky <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
            if (push && !in_legal)
                sticky <= 1'b1;
        end
    end

    // Storage is zeroed on reset so out_* read as zero while the queue is empty after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_funct5[i] <= '0;
                st_rs1[i]    <= '0;
                st_rs2[i]    <= '0;
                st_rs3[i]    <= '0;
                st_tag[i]    <= 1'b0;
            end
        end else if (push && !flush) begin
            st_funct5[wr_ptr] <= in_funct5;
            st_rs1[wr_ptr]    <= in_rs1;
            st_rs2[wr_ptr]    <= in_rs2;
            st_rs3[wr_ptr]    <= in_rs3;
            st_tag[wr_ptr]    <= !in_legal;
        end
    end

endmodule
